// File: rtl/regfile_pkg.sv
// Shared constants and types for the 31+1 entry register file.
package regfile_pkg;
    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/reg_word.sv
// One storage word of the register file: synchronous clear, write-enabled load.
module reg_word
    import regfile_pkg::*;
#(
    parameter int W = regfile_pkg::DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] word_d;
    logic [W-1:0] word_q;

    always_comb begin
        word_d = word_q;
        if (we) begin
            word_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign q = word_q;

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file; X31 is hard-wired to zero.
// Defining REGFILE_BYPASS_EN forwards a same-cycle write to the read ports.
module reg_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [4:0]        read_reg1,
    input  logic [4:0]        read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    logic [NUM_REGS-2:0] we_onehot;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [DATA_W-1:0]   stored1;
    logic [DATA_W-1:0]   stored2;

    // The decode never produces an enable for index 31, so writes there vanish.
    always_comb begin
        we_onehot = '0;
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            we_onehot[i] = reg_write && (write_reg == 5'(i));
        end
    end

    for (genvar g = 0; g < NUM_REGS - 1; g++) begin : g_word
        reg_word #(.W(DATA_W)) u_word (
            .clk   (clk),
            .reset (reset),
            .we    (we_onehot[g]),
            .d     (write_data),
            .q     (regs[g])
        );
    end

    assign regs[NUM_REGS-1] = '0;

    always_comb begin
        stored1 = regs[read_reg1];
        stored2 = regs[read_reg2];
        if (read_reg1 == ZERO_REG) begin
            stored1 = '0;
        end
        if (read_reg2 == ZERO_REG) begin
            stored2 = '0;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_ok;

    // A write that reset will discard must not be forwarded either.
    always_comb begin
        fwd_ok     = reg_write && !reset && (write_reg != ZERO_REG);
        read_data1 = stored1;
        read_data2 = stored2;
        if (fwd_ok && (read_reg1 == write_reg)) begin
            read_data1 = write_data;
        end
        if (fwd_ok && (read_reg2 == write_reg)) begin
            read_data2 = write_data;
        end
    end
`else
    assign read_data1 = stored1;
    assign read_data2 = stored2;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Randomised and directed bench for reg_file against an array-based model.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [63:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [63:0] read_data1;
    logic [63:0] read_data2;

    logic [63:0] model [32];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    reg_file dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    // Architectural view of a read in the current cycle.
    function automatic logic [63:0] exp_read(input logic [4:0] idx);
`ifdef REGFILE_BYPASS_EN
        if (reg_write && !reset && write_reg != 5'd31 && idx == write_reg) return write_data;
`endif
        if (idx == 5'd31) return 64'h0;
        return model[idx];
    endfunction

    task automatic drive(input logic rst, input logic we, input logic [4:0] wr,
                         input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        reset      = rst;
        reg_write  = we;
        write_reg  = wr;
        write_data = wd;
        read_reg1  = r1;
        read_reg2  = r2;
        #1;
    endtask

    // Advance across one rising edge, updating the model, and stop at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 64'h0;
        end else if (reg_write && write_reg != 5'd31) begin
            model[write_reg] = write_data;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
        tick();
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i));
            n_cmp++;
            if (read_data1 !== 64'h0) begin
                n_err++;
                $display("FAIL reset_sweep_p1[%0d]: got %h expected 0", i, read_data1);
            end
            n_cmp++;
            if (read_data2 !== 64'h0) begin
                n_err++;
                $display("FAIL reset_sweep_p2[%0d]: got %h expected 0", 31 - i, read_data2);
            end
        end
    endtask

    task automatic test_write_read();
        drive(1'b0, 1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd5, 5'd5);
        n_cmp++;
        if (read_data1 !== 64'hDEADBEEF_CAFEF00D) begin
            n_err++;
            $display("FAIL x5_p1: got %h expected deadbeefcafef00d", read_data1);
        end
        n_cmp++;
        if (read_data2 !== 64'hDEADBEEF_CAFEF00D) begin
            n_err++;
            $display("FAIL x5_p2: got %h expected deadbeefcafef00d", read_data2);
        end
        drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd4, 5'd6);
        n_cmp++;
        if (read_data1 !== 64'h0) begin
            n_err++;
            $display("FAIL x4_neighbour: got %h expected 0", read_data1);
        end
        n_cmp++;
        if (read_data2 !== 64'h0) begin
            n_err++;
            $display("FAIL x6_neighbour: got %h expected 0", read_data2);
        end
    endtask

    task automatic test_zero_reg();
        drive(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
        n_cmp++;
        if (read_data1 !== 64'h0) begin
            n_err++;
            $display("FAIL x31_same_cycle: got %h expected 0", read_data1);
        end
        tick();
        drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd31, 5'd31);
        n_cmp++;
        if (read_data1 !== 64'h0 || read_data2 !== 64'h0) begin
            n_err++;
            $display("FAIL x31_after_write: got %h/%h expected 0/0", read_data1, read_data2);
        end
    endtask

    task automatic test_no_write_and_reset();
        drive(1'b0, 1'b0, 5'd7, 64'h1234, 5'd7, 5'd7);
        tick();
        drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd7, 5'd7);
        n_cmp++;
        if (read_data1 !== 64'h0) begin
            n_err++;
            $display("FAIL x7_no_we: got %h expected 0", read_data1);
        end
        drive(1'b0, 1'b1, 5'd8, 64'h0BAD_F00D, 5'd0, 5'd0);
        tick();
        // Reset pending: old contents still visible, and no forwarding of X7.
        drive(1'b1, 1'b1, 5'd7, 64'h55, 5'd8, 5'd7);
        n_cmp++;
        if (read_data1 !== 64'h0BAD_F00D) begin
            n_err++;
            $display("FAIL pre_reset_old_x8: got %h expected 0badf00d", read_data1);
        end
        n_cmp++;
        if (read_data2 !== 64'h0) begin
            n_err++;
            $display("FAIL reset_no_forward_x7: got %h expected 0", read_data2);
        end
        tick();
        drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd7, 5'd8);
        n_cmp++;
        if (read_data1 !== 64'h0) begin
            n_err++;
            $display("FAIL x7_reset_wins: got %h expected 0", read_data1);
        end
        n_cmp++;
        if (read_data2 !== 64'h0) begin
            n_err++;
            $display("FAIL x8_cleared: got %h expected 0", read_data2);
        end
    endtask

    task automatic test_bypass();
        logic [63:0] exp_now;
`ifdef REGFILE_BYPASS_EN
        exp_now = 64'hA;
`else
        exp_now = 64'h0;
`endif
        drive(1'b0, 1'b1, 5'd10, 64'hA, 5'd10, 5'd11);
        n_cmp++;
        if (read_data1 !== exp_now) begin
            n_err++;
            $display("FAIL x10_same_cycle: got %h expected %h", read_data1, exp_now);
        end
        tick();
        drive(1'b0, 1'b0, 5'd10, 64'hFF, 5'd10, 5'd10);
        n_cmp++;
        if (read_data1 !== 64'hA || read_data2 !== 64'hA) begin
            n_err++;
            $display("FAIL x10_next_cycle: got %h/%h expected a/a", read_data1, read_data2);
        end
    endtask

    task automatic test_all_regs();
        for (int i = 0; i < 31; i++) begin
            drive(1'b0, 1'b1, 5'(i), 64'(i), 5'(i), 5'(30 - i));
            tick();
        end
        for (int i = 0; i <= 30; i++) begin
            drive(1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(30 - i));
            n_cmp++;
            if (read_data1 !== 64'(i) || read_data2 !== 64'(30 - i)) begin
                n_err++;
                $display("FAIL pair_%0d_%0d: got %h/%h expected %h/%h", i, 30 - i,
                         read_data1, read_data2, 64'(i), 64'(30 - i));
            end
        end
    endtask

    task automatic test_random();
        logic [4:0]  wr;
        logic [63:0] e1;
        logic [63:0] e2;
        for (int n = 0; n < 300; n++) begin
            wr = 5'($urandom_range(0, 31));
            drive($urandom_range(0, 24) == 0, 1'($urandom_range(0, 1)), wr,
                  {$urandom, $urandom},
                  ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)));
            e1 = exp_read(read_reg1);
            e2 = exp_read(read_reg2);
            n_cmp++;
            if (read_data1 !== e1) begin
                n_err++;
                $display("FAIL rand_p1[%0d] idx %0d: got %h expected %h", n, read_reg1, read_data1, e1);
            end
            n_cmp++;
            if (read_data2 !== e2) begin
                n_err++;
                $display("FAIL rand_p2[%0d] idx %0d: got %h expected %h", n, read_reg2, read_data2, e2);
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        drive(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
        @(negedge clk);
        test_reset();
        test_write_read();
        test_zero_reg();
        test_no_write_and_reset();
        test_bypass();
        test_all_regs();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
